// File: rtl/fifo_fwft_rd_stage.sv
// fifo_fwft_rd_stage: converts the FIFO rd_en/empty pop port (1-cycle read latency) into an FWFT valid/ready stream.
// Latency: rd_en in cycle c -> word captured at end of c+1 -> m_valid in c+2; sustains one word per cycle.
// Backpressure: 2-entry skid buffer; rd_en is withheld once held + in-flight words would exceed 2.
// Optional feature: define FWFT_OCC_EN to add the occ port (held entries plus in-flight read).
module fifo_fwft_rd_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FWFT_OCC_EN
  ,
  output logic [1:0]            occ
`endif
);

  logic [1:0]            r_cnt;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic                  w_pop;
  logic [2:0]            w_fill;
  logic                  w_cap_head;
  logic                  w_cap_tail;
  logic                  w_shift;

  assign m_valid = (r_cnt != 2'd0);
  assign m_data  = r_head;
  assign w_pop   = m_valid & m_ready;

  // Occupancy after this edge; a pop always has cnt >= 1, so no underflow.
  assign w_fill = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};

  // Only request a word that is guaranteed a free slot when it lands next cycle.
  assign rd_en = rrst_n & ~fifo_empty & (w_fill < 3'd2);

  // Landing word goes to head when the buffer is (or is about to become) empty,
  // otherwise behind the current head. A pop from two entries shifts tail forward.
  assign w_cap_head = r_pend & ((r_cnt == 2'd0) | ((r_cnt == 2'd1) & w_pop));
  assign w_cap_tail = r_pend & ~w_cap_head;
  assign w_shift    = w_pop & (r_cnt == 2'd2);

  // Entry count and in-flight read flag.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_cnt  <= 2'd0;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= w_fill[1:0];
      r_pend <= rd_en;
    end
  end

  // Head slot: loaded from the memory port or from tail on a full-buffer pop.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_head <= '0;
    end else if (w_cap_head) begin
      r_head <= fifo_rdata;
    end else if (w_shift) begin
      r_head <= r_tail;
    end
  end

  // Tail slot: holds the second word while the consumer stalls.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_tail <= '0;
    end else if (w_cap_tail) begin
      r_tail <= fifo_rdata;
    end
  end

`ifdef FWFT_OCC_EN
  assign occ = r_cnt + {1'b0, r_pend};
`endif

endmodule

// File: tb/tb_fifo_fwft_rd_stage.sv
// tb_fifo_fwft_rd_stage: directed table vectors plus hand sequences against a queue model of the FIFO.
// Latency: each cycle drives inputs 1 time unit after posedge and samples outputs on the negedge.
// Backpressure: the queue model pops one word per sampled rd_en and presents it on fifo_rdata next cycle.
module tb_fifo_fwft_rd_stage;

  logic       rclk;
  logic       rrst_n;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FWFT_OCC_EN
  logic [1:0] occ;
`endif

  fifo_fwft_rd_stage #(.DATA_WIDTH(8)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FWFT_OCC_EN
    ,
    .occ        (occ)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       pv;
    logic [7:0] pd;
    logic       e_rd;
    logic       e_mv;
    logic [7:0] e_md;
    logic [1:0] e_oc;
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] q[$];
  logic [7:0] got[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       s_rd, s_mv, s_pop;
  logic [7:0] s_md;
  logic [1:0] s_oc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus, sampling and FIFO model update.
  task automatic cyc(input logic rst, input logic rdy, input logic pv, input logic [7:0] pd);
    rrst_n  = rst;
    m_ready = rdy;
    if (pv) q.push_back(pd);
    if (!rst) begin
      q.delete();
      fifo_empty = 1'b0;
    end else begin
      fifo_empty = (q.size() == 0);
    end
    @(negedge rclk);
    s_rd  = rd_en;
    s_mv  = m_valid;
    s_md  = m_data;
    s_pop = m_valid & m_ready;
`ifdef FWFT_OCC_EN
    s_oc  = occ;
`else
    s_oc  = 2'd0;
`endif
    if (s_pop) got.push_back(m_data);
    @(posedge rclk);
    #1;
    if (s_rd) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_en_on_empty: got rd_en=1, want 0");
      end else begin
        fifo_rdata = q.pop_front();
      end
    end
  endtask

  initial begin
    int first_rd, first_mv, first_pop, last_pop, stall_rd;
    logic [7:0] hold_md;
    logic       prev_mv, prev_pop;

    rrst_n = 1'b0; m_ready = 1'b0; fifo_empty = 1'b0; fifo_rdata = 8'h00;
    @(posedge rclk);
    #1;

    //            rst rdy pv  pd      rd  mv  md     oc
    tbl[0]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,2'd0};
    tbl[1]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,2'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,2'd0};
    tbl[3]  = '{1'b1,1'b1,1'b1,8'h5A, 1'b1,1'b0,8'h00,2'd0};
    tbl[4]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,8'h00,2'd1};
    tbl[5]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h5A,2'd1};
    tbl[6]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,8'h5A,2'd1};
    tbl[7]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,8'h5A,2'd0};
    tbl[8]  = '{1'b1,1'b0,1'b1,8'h31, 1'b1,1'b0,8'h5A,2'd0};
    tbl[9]  = '{1'b1,1'b0,1'b1,8'h32, 1'b1,1'b0,8'h5A,2'd1};
    tbl[10] = '{1'b1,1'b0,1'b1,8'h33, 1'b0,1'b1,8'h31,2'd2};
    tbl[11] = '{1'b1,1'b0,1'b1,8'h34, 1'b0,1'b1,8'h31,2'd2};
    tbl[12] = '{1'b1,1'b1,1'b0,8'h00, 1'b1,1'b1,8'h31,2'd2};
    tbl[13] = '{1'b1,1'b1,1'b0,8'h00, 1'b1,1'b1,8'h32,2'd2};
    tbl[14] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,8'h33,2'd2};
    tbl[15] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,8'h34,2'd1};
    tbl[16] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,8'h34,2'd0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].pv, tbl[i].pd);
      chk($sformatf("tbl%0d_rd_en", i), {31'd0, s_rd}, {31'd0, tbl[i].e_rd});
      chk($sformatf("tbl%0d_m_valid", i), {31'd0, s_mv}, {31'd0, tbl[i].e_mv});
      chk($sformatf("tbl%0d_m_data", i), {24'd0, s_md}, {24'd0, tbl[i].e_md});
`ifdef FWFT_OCC_EN
      chk($sformatf("tbl%0d_occ", i), {30'd0, s_oc}, {30'd0, tbl[i].e_oc});
`endif
    end

    // Streaming 0x11..0x18 with m_ready high.
    got.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'h11 + 8'(i));
    first_rd = -1; first_mv = -1; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 14; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      if (s_rd && first_rd < 0) first_rd = c;
      if (s_mv && first_mv < 0) first_mv = c;
      if (s_pop) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
    end
    chk("stream_latency", first_mv - first_rd, 2);
    chk("stream_burst_len", last_pop - first_pop, 7);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("stream_word%0d", i), {24'd0, got[i]}, 32'h11 + i);
    chk("stream_drained", {31'd0, s_mv}, 0);

    // Backpressure: stall 5 cycles mid-stream of 0x21..0x26.
    got.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'h21 + 8'(i));
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    stall_rd = 0;
    hold_md = 8'h00;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      if (s_rd) stall_rd++;
      if (c == 0) hold_md = s_md;
      chk($sformatf("bp_valid_c%0d", c), {31'd0, s_mv}, 1);
      if (c > 0) chk($sformatf("bp_data_stable_c%0d", c), {24'd0, s_md}, {24'd0, hold_md});
      if (c >= 2) chk($sformatf("bp_no_rd_c%0d", c), {31'd0, s_rd}, 0);
    end
    chk("bp_extra_rd_le2", {31'd0, (stall_rd <= 2)}, 1);
`ifdef FWFT_OCC_EN
    chk("bp_occ_full", {30'd0, s_oc}, 2);
`endif
    for (int c = 0; c < 12; c++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk($sformatf("bp_word%0d", i), {24'd0, got[i]}, 32'h21 + i);

    // Alternating m_ready with a non-empty FIFO.
    got.delete();
    for (int i = 0; i < 12; i++) q.push_back(8'h40 + 8'(i));
    prev_mv = 1'b0; prev_pop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b1, (c % 2 == 0), 1'b0, 8'h00);
      if (prev_mv && !prev_pop) chk($sformatf("alt_valid_held_c%0d", c), {31'd0, s_mv}, 1);
      prev_mv = s_mv; prev_pop = s_pop;
    end
    chk("alt_count", got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("alt_word%0d", i), {24'd0, got[i]}, 32'h40 + i);

    // Reset with two words held/in flight; first post-reset word must be the new one.
    for (int i = 0; i < 6; i++) q.push_back(8'h60 + 8'(i));
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef FWFT_OCC_EN
    chk("rst_pre_occ", {30'd0, occ}, 2);
`endif
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    got.delete();
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    chk("rst_post_valid", {31'd0, s_mv}, 0);
    chk("rst_post_data", {24'd0, s_md}, 0);
`ifdef FWFT_OCC_EN
    chk("rst_post_occ", {30'd0, s_oc}, 0);
`endif
    for (int c = 0; c < 6; c++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("rst_post_count", got.size(), 1);
    if (got.size() > 0) chk("rst_post_word", {24'd0, got[0]}, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
